// File: rtl/invert_serial.sv
// Bit-serial two's-complement negator, LSB first, one independent flag per lane.
// Define INVERT_REG_OUT_EN to register y (adds one cycle of latency).
module invert_serial #(
  parameter int unsigned LANES = 1
) (
  input  logic [LANES-1:0] i,
  input  logic             r,
  input  logic             t_clk,
  output logic [LANES-1:0] y
);

  logic [LANES-1:0] r_seen;
  logic [LANES-1:0] w_y;

  // Invert only once a 1 has passed in this word; r forces pass-through of the LSB.
  assign w_y = i ^ (r_seen & {LANES{~r}});

  // r starts a new word: drop old history and absorb the LSB.
  always_ff @(posedge t_clk) begin
    if (r) begin
      r_seen <= i;
    end else begin
      r_seen <= r_seen | i;
    end
  end

`ifdef INVERT_REG_OUT_EN
  logic [LANES-1:0] r_y;

  // On an r edge w_y equals i, so the registered LSB result doubles as the reset value.
  always_ff @(posedge t_clk) begin
    r_y <= w_y;
  end

  assign y = r_y;
`else
  assign y = w_y;
`endif

endmodule

// File: tb/tb_invert_serial.sv
// Directed, table-driven bench for invert_serial with two lanes.
// Handles both the combinational and the INVERT_REG_OUT_EN (one-cycle) builds.
module tb_invert_serial;

  localparam int unsigned LANES = 2;

  typedef struct packed {
    logic             r;
    logic [LANES-1:0] i;
    logic [LANES-1:0] y;
  } vec_t;

  logic             t_clk;
  logic             r;
  logic [LANES-1:0] i;
  logic [LANES-1:0] y;

  vec_t             vecs[$];
  int               n_tests;
  int               n_fail;
  logic [LANES-1:0] prev_exp;
  logic             have_prev;

  invert_serial #(.LANES(LANES)) dut (
    .i     (i),
    .r     (r),
    .t_clk (t_clk),
    .y     (y)
  );

  initial t_clk = 1'b0;
  always #5 t_clk = ~t_clk;

  task automatic check(input string name, input logic [LANES-1:0] act, input logic [LANES-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got y=%b expected y=%b", name, act, exp);
    end
  endtask

  // Drive one bit-time on the falling edge; expected y follows the build's latency.
  task automatic step(input string name, input logic rr, input logic [LANES-1:0] ii, input logic [LANES-1:0] yy);
    @(negedge t_clk);
`ifdef INVERT_REG_OUT_EN
    if (have_prev) check(name, y, prev_exp);
`endif
    r = rr;
    i = ii;
    #1;
`ifndef INVERT_REG_OUT_EN
    check(name, y, yy);
`endif
    prev_exp  = yy;
    have_prev = 1'b1;
  endtask

  task automatic add(input logic rr, input logic [LANES-1:0] ii, input logic [LANES-1:0] yy);
    vec_t v;
    v.r = rr;
    v.i = ii;
    v.y = yy;
    vecs.push_back(v);
  endtask

  // Bit k of each argument is the bit at time k of the word (LSB first).
  task automatic add_word(input int n, input logic [15:0] l0i, input logic [15:0] l0y,
                          input logic [15:0] l1i, input logic [15:0] l1y);
    for (int k = 0; k < n; k++) begin
      add(k == 0, {l1i[k], l0i[k]}, {l1y[k], l0y[k]});
    end
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    have_prev = 1'b0;
    prev_exp  = '0;
    r         = 1'b1;
    i         = '0;

    // init
    add(1'b1, 2'b00, 2'b00);
    // lane0: 0101 -> 1011 (-5); lane1: 6 -> 10
    add_word(4, 16'b0101, 16'b1011, 16'b0110, 16'b1010);
    // back-to-back: lane0 203 -> 53, lane1 zero word right after a seen=1 word
    add_word(8, 16'b11001011, 16'b00110101, 16'b0, 16'b0);
    // lane0 zero word; lane1 LSBs 0,0 then 1: 180 -> 76
    add_word(8, 16'b0, 16'b0, 16'b10110100, 16'b01001100);
    // lane0 most-negative 4-bit; lane1 1111 -> 0001
    add_word(4, 16'b1000, 16'b1000, 16'b1111, 16'b0001);
    // r held high two cycles: each bit treated as an LSB
    add(1'b1, 2'b01, 2'b01);
    add(1'b1, 2'b11, 2'b11);
    add(1'b0, 2'b01, 2'b10);
    add(1'b1, 2'b00, 2'b00);
    add(1'b0, 2'b11, 2'b11);
    add(1'b0, 2'b00, 2'b11);

    foreach (vecs[k]) begin
      step($sformatf("vec%0d", k), vecs[k].r, vecs[k].i, vecs[k].y);
    end

    // Long word: lane0 = 0,0,1 then random bits (inverted); lane1 = all ones.
    for (int k = 0; k < 20; k++) begin
      logic b;
      logic e0;
      logic e1;
      b  = (k < 2) ? 1'b0 : (k == 2) ? 1'b1 : 1'($urandom_range(0, 1));
      e0 = (k <= 2) ? b : ~b;
      e1 = (k == 0) ? 1'b1 : 1'b0;
      step($sformatf("long%0d", k), k == 0, {1'b1, b}, {e1, e0});
    end

    // Flush so the registered build checks the last bit as well.
    step("flush", 1'b1, 2'b00, 2'b00);
    step("flush2", 1'b1, 2'b00, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
